// File: rtl/stream_min2_if.sv
// Frame-in / result-out bundle for the two-smallest-element finder.
interface stream_min2_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned IDX_W  = 4
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] min1;
  logic [DATA_W-1:0] min2;
  logic [IDX_W-1:0]  idx_min1;
  logic [IDX_W-1:0]  idx_min2;
  logic              min2_valid;
  logic [IDX_W:0]    count;
  logic              overflow;

  modport master (
    output start, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, min1, min2, idx_min1, idx_min2,
           min2_valid, count, overflow
  );

  modport slave (
    input  start, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, min1, min2, idx_min1, idx_min2,
           min2_valid, count, overflow
  );
endinterface

// File: rtl/stream_min2_finder.sv
// Streams one frame of unsigned elements and reports the smallest and
// second-smallest values with their frame positions (lowest index wins ties).
module stream_min2_finder #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  stream_min2_if.slave  bus
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] min1_q;
  logic [DATA_W-1:0] min2_q;
  logic [IDX_W-1:0]  idx1_q;
  logic [IDX_W-1:0]  idx2_q;
  logic              full1_q;
  logic              full2_q;
  logic              min2_valid_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;

  logic accept_c;
  logic clear_c;
  logic close_c;
  logic at_depth_c;
  logic lt1_c;
  logic lt2_c;

  // Next state plus the single comparator pair; an empty slot beats any value.
  always_comb begin
    state_next = state;
    clear_c    = 1'b0;
    close_c    = 1'b0;
    accept_c   = bus.in_valid & in_ready_q;
    at_depth_c = (count_q == CNT_W'(DEPTH - 1));
    lt1_c      = !full1_q || (bus.in_data < min1_q);
    lt2_c      = !full2_q || (bus.in_data < min2_q);
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = ACCUM;
          clear_c    = 1'b1;
        end
      end
      ACCUM: begin
        if (accept_c && (bus.in_last || at_depth_c)) begin
          state_next = DONE;
          close_c    = 1'b1;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      in_ready_q  <= (state_next == ACCUM);
      out_valid_q <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min1_q       <= '1;
      min2_q       <= '1;
      idx1_q       <= '1;
      idx2_q       <= '1;
      full1_q      <= 1'b0;
      full2_q      <= 1'b0;
      min2_valid_q <= 1'b0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else if (clear_c) begin
      min1_q       <= '1;
      min2_q       <= '1;
      idx1_q       <= '1;
      idx2_q       <= '1;
      full1_q      <= 1'b0;
      full2_q      <= 1'b0;
      min2_valid_q <= 1'b0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else if (accept_c) begin
      count_q <= count_q + CNT_W'(1);
      if (lt1_c) begin
        min2_q  <= min1_q;
        idx2_q  <= idx1_q;
        full2_q <= full1_q;
        min1_q  <= bus.in_data;
        idx1_q  <= IDX_W'(count_q);
        full1_q <= 1'b1;
      end else if (lt2_c) begin
        min2_q  <= bus.in_data;
        idx2_q  <= IDX_W'(count_q);
        full2_q <= 1'b1;
      end
      // count_q is still the index of the closing element here.
      if (close_c) begin
        min2_valid_q <= (count_q != '0);
        overflow_q   <= at_depth_c & ~bus.in_last;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.min1       = min1_q;
  assign bus.min2       = min2_q;
  assign bus.idx_min1   = idx1_q;
  assign bus.idx_min2   = idx2_q;
  assign bus.min2_valid = min2_valid_q;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_stream_min2_finder.sv
// Directed bench for stream_min2_finder with DATA_W=4, DEPTH=16.
module tb_stream_min2_finder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   vec [16];

  always #5 clk = ~clk;

  stream_min2_if #(.DATA_W(4), .IDX_W(4)) bus ();

  stream_min2_finder #(.DATA_W(4), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input int m1, input int i1, input int m2,
                              input int i2, input int mv, input int cnt, input int ov);
    check({tag, "_min1"},       32'(bus.min1),       32'(m1));
    check({tag, "_idx_min1"},   32'(bus.idx_min1),   32'(i1));
    check({tag, "_min2"},       32'(bus.min2),       32'(m2));
    check({tag, "_idx_min2"},   32'(bus.idx_min2),   32'(i2));
    check({tag, "_min2_valid"}, 32'(bus.min2_valid), 32'(mv));
    check({tag, "_count"},      32'(bus.count),      32'(cnt));
    check({tag, "_overflow"},   32'(bus.overflow),   32'(ov));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check_result(tag, 15, 15, 15, 15, 0, 0, 0);
  endtask

  // Opens a frame and streams vec[0..n-1] back to back.
  task automatic run_frame(input int n, input bit use_last, input string tag);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check({tag, "_ready"}, 32'(bus.in_ready), 1);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) check({tag, "_pre_valid"}, 32'(bus.out_valid), 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 4'(vec[i]);
      bus.in_last  = use_last && (i == n - 1);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check({tag, "_out_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_busy"},      32'(bus.in_ready),  0);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_drained"}, 32'(bus.out_valid), 0);
    check({tag, "_idle"},    32'(bus.in_ready),  0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    check_reset_state("reset");
    rst_n = 1'b1;
    step();

    vec = '{2, 3, 1, 2, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(6, 1'b1, "f_basic");
    check_result("f_basic", 1, 2, 2, 0, 1, 6, 0);
    release_result("f_basic");

    vec = '{1, 4, 2, 1, 2, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(6, 1'b1, "f_dup");
    check_result("f_dup", 1, 0, 1, 3, 1, 6, 0);
    release_result("f_dup");

    vec = '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(1, 1'b1, "f_single");
    check_result("f_single", 7, 0, 15, 15, 0, 1, 0);
    release_result("f_single");

    vec = '{15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15};
    run_frame(16, 1'b0, "f_ovf");
    check_result("f_ovf", 15, 0, 15, 1, 1, 16, 1);
    release_result("f_ovf");

    vec = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    run_frame(16, 1'b1, "f_full_last");
    check_result("f_full_last", 0, 15, 1, 14, 1, 16, 0);
    release_result("f_full_last");

    // Result held under backpressure; start and in_valid must be ignored.
    vec = '{5, 2, 10, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(6, 1'b1, "f_bp");
    check_result("f_bp", 0, 3, 1, 5, 1, 6, 0);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd0;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_in_ready",  32'(bus.in_ready),  0);
      check("bp_min1",      32'(bus.min1),      0);
      check("bp_idx_min2",  32'(bus.idx_min2),  5);
      check("bp_count",     32'(bus.count),     6);
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    release_result("f_bp");

    // Reset in the middle of a frame discards it.
    vec = '{9, 3, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 4'(vec[i]);
      step();
    end
    check("mid_count", 32'(bus.count), 3);
    rst_n = 1'b0;
    #2;
    check_reset_state("mid_reset");
    #10;
    rst_n = 1'b1;
    bus.in_last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("post_reset_out_valid", 32'(bus.out_valid), 0);
      check("post_reset_count",     32'(bus.count),     0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
